// File: rtl/window_ctrl.sv
// Sliding-window sequencer: runs an external simple-dual-port RAM as a circular delay line and
// emits (new, evicted) sample pairs. Define WINDOW_CTRL_FILL_OUT_EN to also emit pairs while filling.
module window_ctrl #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned MAX_DEPTH = 1024,
  localparam int unsigned AW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW:0]      cfg_len,
  input  logic             cfg_load,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             mem_rd_en,
  output logic [AW-1:0]    mem_rd_addr,
  input  logic [WIDTH-1:0] mem_rd_data,
  output logic             mem_wr_en,
  output logic [AW-1:0]    mem_wr_addr,
  output logic [WIDTH-1:0] mem_wr_data,
  output logic [WIDTH-1:0] out_new,
  output logic [WIDTH-1:0] out_old,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             primed
);
  localparam int unsigned   LW      = AW + 1;
  localparam logic [LW-1:0] MAX_LEN = LW'(MAX_DEPTH);
  localparam logic [1:0]    ST_IDLE = 2'd0;
  localparam logic [1:0]    ST_FILL = 2'd1;
  localparam logic [1:0]    ST_RUN  = 2'd2;
`ifdef WINDOW_CTRL_FILL_OUT_EN
  localparam logic FILL_OUT = 1'b1;
`else
  localparam logic FILL_OUT = 1'b0;
`endif

  logic [1:0]       state_q, state_d;
  logic [LW-1:0]    len_q, len_d, fill_q, fill_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic             primed_q, primed_d;
  // Read-issue stage: holds the accepted sample while its RAM read returns.
  logic             s1_valid_q, s1_valid_d, s1_fresh_q, s1_fresh_d;
  logic             s1_run_q, s1_run_d, s1_emit_q, s1_emit_d, s1_fwd_q, s1_fwd_d;
  logic [WIDTH-1:0] s1_data_q, s1_data_d, s1_fwd_data_q, s1_fwd_data_d, s1_old_q, s1_old_d;
  logic             wr_en_q, wr_en_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_new_q, out_new_d, out_old_q, out_old_d;

  logic             in_ready_c, accept_c, s2_free_c, s1_adv_c;
  logic [WIDTH-1:0] old_now_c, old_sel_c;

  assign s2_free_c  = !out_valid_q || out_ready;
  assign s1_adv_c   = s1_valid_q && (!s1_emit_q || s2_free_c);
  assign in_ready_c = (state_q != ST_IDLE) && !cfg_load &&
                      !(s1_valid_q && s1_emit_q && out_valid_q && !out_ready);
  assign accept_c   = in_valid && in_ready_c;

  // Evicted sample: zero while filling, forwarded on a same-address write/read collision.
  always_comb begin
    old_now_c = '0;
    if (s1_run_q) old_now_c = s1_fwd_q ? s1_fwd_data_q : mem_rd_data;
    old_sel_c = s1_fresh_q ? old_now_c : s1_old_q;
  end

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    fill_d        = fill_q;
    ptr_d         = ptr_q;
    primed_d      = primed_q;
    s1_valid_d    = s1_valid_q;
    s1_fresh_d    = 1'b0;
    s1_run_d      = s1_run_q;
    s1_emit_d     = s1_emit_q;
    s1_fwd_d      = s1_fwd_q;
    s1_data_d     = s1_data_q;
    s1_fwd_data_d = s1_fwd_data_q;
    s1_old_d      = old_sel_c;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    out_valid_d   = out_valid_q;
    out_new_d     = out_new_q;
    out_old_d     = out_old_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (s1_adv_c) begin
      s1_valid_d = 1'b0;
      if (s1_emit_q) begin
        out_valid_d = 1'b1;
        out_new_d   = s1_data_q;
        out_old_d   = old_sel_c;
      end
    end

    if (accept_c) begin
      s1_valid_d    = 1'b1;
      s1_fresh_d    = 1'b1;
      s1_data_d     = in_data;
      s1_run_d      = (state_q == ST_RUN);
      s1_emit_d     = (state_q == ST_RUN) || FILL_OUT;
      s1_fwd_d      = wr_en_q && (wr_addr_q == ptr_q);
      s1_fwd_data_d = wr_data_q;
      wr_en_d       = 1'b1;
      wr_addr_d     = ptr_q;
      wr_data_d     = in_data;
      ptr_d         = ({1'b0, ptr_q} == len_q - LW'(1)) ? '0 : ptr_q + AW'(1);
      if (state_q == ST_FILL) begin
        fill_d = fill_q + LW'(1);
        if (fill_d == len_q) begin
          state_d  = ST_RUN;
          primed_d = 1'b1;
        end
      end
    end

    if (cfg_load) begin
      state_d     = ST_FILL;
      if (cfg_len == '0)          len_d = LW'(1);
      else if (cfg_len > MAX_LEN) len_d = MAX_LEN;
      else                        len_d = cfg_len;
      ptr_d       = '0;
      fill_d      = '0;
      primed_d    = 1'b0;
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      len_q         <= MAX_LEN;
      fill_q        <= '0;
      ptr_q         <= '0;
      primed_q      <= 1'b0;
      s1_valid_q    <= 1'b0;
      s1_fresh_q    <= 1'b0;
      s1_run_q      <= 1'b0;
      s1_emit_q     <= 1'b0;
      s1_fwd_q      <= 1'b0;
      s1_data_q     <= '0;
      s1_fwd_data_q <= '0;
      s1_old_q      <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      out_valid_q   <= 1'b0;
      out_new_q     <= '0;
      out_old_q     <= '0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      fill_q        <= fill_d;
      ptr_q         <= ptr_d;
      primed_q      <= primed_d;
      s1_valid_q    <= s1_valid_d;
      s1_fresh_q    <= s1_fresh_d;
      s1_run_q      <= s1_run_d;
      s1_emit_q     <= s1_emit_d;
      s1_fwd_q      <= s1_fwd_d;
      s1_data_q     <= s1_data_d;
      s1_fwd_data_q <= s1_fwd_data_d;
      s1_old_q      <= s1_old_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      out_valid_q   <= out_valid_d;
      out_new_q     <= out_new_d;
      out_old_q     <= out_old_d;
    end
  end

  assign in_ready    = in_ready_c;
  assign mem_rd_en   = accept_c;
  assign mem_rd_addr = ptr_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_addr = wr_addr_q;
  assign mem_wr_data = wr_data_q;
  assign out_new     = out_new_q;
  assign out_old     = out_old_q;
  assign out_valid   = out_valid_q;
  assign primed      = primed_q;

endmodule

// File: tb/tb_window_ctrl.sv
// Bench for window_ctrl: RAM model plus a window-history reference model (sample k pairs with
// sample k-len, or 0 while filling). Honours WINDOW_CTRL_FILL_OUT_EN like the design.
module tb_window_ctrl;
  localparam int unsigned WIDTH     = 16;
  localparam int unsigned MAX_DEPTH = 1024;
  localparam int unsigned AW        = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
`ifdef WINDOW_CTRL_FILL_OUT_EN
  localparam bit FILL_OUT = 1'b1;
`else
  localparam bit FILL_OUT = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic [AW:0] cfg_len = '0;
  logic cfg_load = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic in_ready, mem_rd_en, mem_wr_en, out_valid, primed;
  logic [AW-1:0] mem_rd_addr, mem_wr_addr;
  logic [WIDTH-1:0] mem_rd_data, mem_wr_data, out_new, out_old;

  window_ctrl #(.WIDTH(WIDTH), .MAX_DEPTH(MAX_DEPTH)) dut (
    .clk(clk), .reset(rst_n), .cfg_len(cfg_len), .cfg_load(cfg_load),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .out_new(out_new), .out_old(out_old), .out_valid(out_valid), .out_ready(out_ready),
    .primed(primed));

  always #5 clk = ~clk;

  // RAM: read data only meaningful the cycle after a read strobe
  logic [WIDTH-1:0] ram [MAX_DEPTH];
  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
    mem_rd_data <= mem_rd_en ? ram[mem_rd_addr] : 16'hDEAD;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  // Reference model
  logic [WIDTH-1:0]   hist[$];
  logic [2*WIDTH-1:0] exp_q[$];
  int                 exp_t[$];
  int                 len_m = MAX_DEPTH;

  function automatic void model_reset();
    len_m = MAX_DEPTH; hist.delete(); exp_q.delete(); exp_t.delete();
  endfunction

  function automatic void model_cfg(input logic [AW:0] cl);
    int c;
    c = int'(cl);
    len_m = (c == 0) ? 1 : (c > int'(MAX_DEPTH)) ? int'(MAX_DEPTH) : c;
    hist.delete(); exp_q.delete(); exp_t.delete();
  endfunction

  function automatic void model_accept(input logic [WIDTH-1:0] d, input int t);
    int k;
    logic [WIDTH-1:0] old;
    k = hist.size();
    old = (k >= len_m) ? hist[k-len_m] : '0;
    hist.push_back(d);
    if (FILL_OUT || k >= len_m) begin
      exp_q.push_back({d, old});
      exp_t.push_back(t);
    end
  endfunction

  // Observations of the last step
  logic s_acc, s_hs, s_ex_ok, s_primed, s_primed_exp, s_in_ready, s_out_valid;
  logic [WIDTH-1:0] s_new, s_old;
  logic [2*WIDTH-1:0] s_ex;
  logic [AW-1:0] s_rd_addr;
  int s_lat, s_k;

  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic rdy,
                      input logic ld, input logic [AW:0] cl);
    int t;
    @(negedge clk);
    in_valid = v; in_data = d; out_ready = rdy; cfg_load = ld; cfg_len = cl;
    #1;
    t = cyc;
    s_acc = in_valid && in_ready;
    s_hs = out_valid && out_ready;
    s_out_valid = out_valid; s_in_ready = in_ready;
    s_new = out_new; s_old = out_old; s_primed = primed; s_rd_addr = mem_rd_addr;
    s_primed_exp = (hist.size() >= len_m);
    s_k = hist.size();
    s_ex_ok = 1'b0; s_ex = '0; s_lat = 0;
    if (s_hs && exp_q.size() > 0) begin
      s_ex_ok = 1'b1; s_ex = exp_q.pop_front(); s_lat = t - exp_t.pop_front();
    end
    @(posedge clk);
    if (ld) model_cfg(cl);
    else if (s_acc) model_accept(d, t);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, mem_rd_en, mem_wr_en, out_valid, primed, out_new, out_old, mem_rd_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b rd=%b wr=%b ov=%b pr=%b new=%h old=%h want all 0",
               in_ready, mem_rd_en, mem_wr_en, out_valid, primed, out_new, out_old);
    end
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, WIDTH'(i + 1), 1'b1, 1'b0, '0);
      checks++;
      if (s_in_ready !== 1'b0 || s_out_valid !== 1'b0) begin
        errors++; $display("FAIL idle_ready: got rdy=%b ov=%b want 0 0", s_in_ready, s_out_valid);
      end
    end
  endtask

  task automatic test_fill4();
    int n = 0;
    step(1'b0, '0, 1'b1, 1'b1, (AW+1)'(4));
    for (int i = 0; i < 14; i++) begin
      step(i < 8, WIDTH'(i + 1), 1'b1, 1'b0, '0);
      if (s_hs) begin
        n++; checks++;
        if (!s_ex_ok || {s_new, s_old} !== s_ex || s_lat != 2) begin
          errors++;
          $display("FAIL fill4_pair: got (%0d,%0d) lat=%0d want (%0d,%0d) lat=2 ok=%b",
                   s_new, s_old, s_lat, s_ex[2*WIDTH-1:WIDTH], s_ex[WIDTH-1:0], s_ex_ok);
        end
      end
      checks++;
      if (s_primed !== s_primed_exp) begin
        errors++; $display("FAIL fill4_primed: got %b want %b at step %0d", s_primed, s_primed_exp, i);
      end
    end
    checks++;
    if (n != (FILL_OUT ? 8 : 4)) begin
      errors++; $display("FAIL fill4_count: got %0d want %0d", n, FILL_OUT ? 8 : 4);
    end
  endtask

  task automatic test_len1();
    int n = 0;
    logic [WIDTH-1:0] d;
    step(1'b0, '0, 1'b1, 1'b1, (AW+1)'(1));
    for (int i = 0; i < 7; i++) begin
      step(i < 3, WIDTH'(10 + i), 1'b1, 1'b0, '0);
      if (s_hs) begin
        n++; checks++;
        if (!s_ex_ok || {s_new, s_old} !== s_ex) begin
          errors++; $display("FAIL len1_pair: got (%0d,%0d) want (%0d,%0d) ok=%b",
                             s_new, s_old, s_ex[2*WIDTH-1:WIDTH], s_ex[WIDTH-1:0], s_ex_ok);
        end
      end
    end
    checks++;
    if (n != (FILL_OUT ? 3 : 2)) begin
      errors++; $display("FAIL len1_count: got %0d want %0d", n, FILL_OUT ? 3 : 2);
    end
    step(1'b0, '0, 1'b1, 1'b1, '0);
    for (int i = 0; i < 12; i++) begin
      d = WIDTH'($urandom);
      step(i < 8, d, 1'b1, 1'b0, '0);
      if (s_hs) begin
        checks++;
        if (!s_ex_ok || {s_new, s_old} !== s_ex) begin
          errors++; $display("FAIL len0_pair: got (%0d,%0d) want (%0d,%0d) ok=%b",
                             s_new, s_old, s_ex[2*WIDTH-1:WIDTH], s_ex[WIDTH-1:0], s_ex_ok);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL len0_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    logic v, r;
    step(1'b0, '0, 1'b1, 1'b1, (AW+1)'(3));
    for (int i = 0; i < 260; i++) begin
      v = (i < 23) ? 1'b1 : (i < 240) ? ($urandom_range(0, 3) != 0) : 1'b0;
      r = (i >= 8 && i < 13) ? 1'b0 : (i < 23 || i >= 240) ? 1'b1 : ($urandom_range(0, 2) != 0);
      step(v, WIDTH'($urandom), r, 1'b0, '0);
      if (i >= 8 && i < 13) begin
        checks++;
        if (s_in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b want 0 at %0d", s_in_ready, i); end
      end
      if (i == 12) begin
        checks++;
        if (exp_q.size() != 2) begin errors++; $display("FAIL bp_pending: got %0d want 2", exp_q.size()); end
      end
      if (s_hs) begin
        checks++;
        if (!s_ex_ok || {s_new, s_old} !== s_ex) begin
          errors++; $display("FAIL bp_pair: got (%0d,%0d) want (%0d,%0d) ok=%b",
                             s_new, s_old, s_ex[2*WIDTH-1:WIDTH], s_ex[WIDTH-1:0], s_ex_ok);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL bp_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_cfg_during_run();
    step(1'b0, '0, 1'b1, 1'b1, (AW+1)'(2));
    for (int i = 0; i < 6; i++) step(1'b1, WIDTH'(100 + i), 1'b1, 1'b0, '0);
    step(1'b1, WIDTH'(99), 1'b1, 1'b1, (AW+1)'(2));
    checks++;
    if (s_acc !== 1'b0 || s_in_ready !== 1'b0) begin
      errors++; $display("FAIL cfg_reject: got acc=%b rdy=%b want 0 0", s_acc, s_in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      step(i < 4, WIDTH'(200 + i), 1'b1, 1'b0, '0);
      if (i == 0) begin
        checks++;
        if (s_out_valid !== 1'b0 || s_primed !== 1'b0) begin
          errors++; $display("FAIL cfg_flush: got ov=%b pr=%b want 0 0", s_out_valid, s_primed);
        end
      end
      if (s_hs) begin
        checks++;
        if (!s_ex_ok || {s_new, s_old} !== s_ex) begin
          errors++; $display("FAIL cfg_pair: got (%0d,%0d) want (%0d,%0d) ok=%b",
                             s_new, s_old, s_ex[2*WIDTH-1:WIDTH], s_ex[WIDTH-1:0], s_ex_ok);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int total;
    total = int'(MAX_DEPTH) + 20;
    step(1'b0, '0, 1'b1, 1'b1, (AW+1)'(MAX_DEPTH + 5));
    for (int i = 0; i < total + 4; i++) begin
      step(i < total, WIDTH'($urandom), 1'b1, 1'b0, '0);
      if (s_acc) begin
        checks++;
        if (int'(s_rd_addr) != (s_k % int'(MAX_DEPTH))) begin
          errors++; $display("FAIL wrap_addr: got %0d want %0d", s_rd_addr, s_k % int'(MAX_DEPTH));
        end
      end
      if (s_hs) begin
        checks++;
        if (!s_ex_ok || {s_new, s_old} !== s_ex) begin
          errors++; $display("FAIL wrap_pair: got (%0d,%0d) want (%0d,%0d) ok=%b",
                             s_new, s_old, s_ex[2*WIDTH-1:WIDTH], s_ex[WIDTH-1:0], s_ex_ok);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_random();
    logic ld;
    for (int i = 0; i < 500; i++) begin
      ld = (i == 0) || ($urandom_range(0, 99) == 0);
      step($urandom_range(0, 3) != 0, WIDTH'($urandom), $urandom_range(0, 9) < 7, ld,
           (AW+1)'($urandom_range(0, 7)));
      checks++;
      if (s_primed !== s_primed_exp || (ld && s_acc)) begin
        errors++; $display("FAIL rand_primed: got pr=%b acc=%b want pr=%b", s_primed, s_acc, s_primed_exp);
      end
      if (s_hs) begin
        checks++;
        if (!s_ex_ok || {s_new, s_old} !== s_ex) begin
          errors++; $display("FAIL rand_pair: got (%0d,%0d) want (%0d,%0d) ok=%b",
                             s_new, s_old, s_ex[2*WIDTH-1:WIDTH], s_ex[WIDTH-1:0], s_ex_ok);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    step(1'b0, '0, 1'b1, 1'b1, (AW+1)'(3));
    for (int i = 0; i < 10; i++) step(1'b1, WIDTH'($urandom), 1'b1, 1'b0, '0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, mem_rd_en, mem_wr_en, out_valid, primed, out_new, out_old} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got rdy=%b rd=%b wr=%b ov=%b pr=%b new=%h old=%h want all 0",
               in_ready, mem_rd_en, mem_wr_en, out_valid, primed, out_new, out_old);
    end
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, WIDTH'(i), 1'b1, 1'b0, '0);
      checks++;
      if (s_in_ready !== 1'b0 || s_out_valid !== 1'b0) begin
        errors++; $display("FAIL midreset_idle: got rdy=%b ov=%b want 0 0", s_in_ready, s_out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill4();
    test_len1();
    test_backpressure();
    test_cfg_during_run();
    test_wrap();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/window_ctrl.md
# window_ctrl

Sequencing controller for the sliding-window sample buffer in the real-time standard-deviation pipeline. Accepts a sample stream, drives an external simple-dual-port RAM as a circular delay line of run-time length, and emits each new sample paired with the sample it evicts from the window. Downstream running-sum/sum-of-squares accumulators consume these pairs. Tracks fill level and flags when the window is primed.

## Interface
- WIDTH, 16, sample width in bits
- MAX_DEPTH, 1024, maximum window length; AW = clog2(MAX_DEPTH), minimum 1
- clk  in  1  clock; all logic rising-edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- cfg_len  in  AW+1  requested window length, sampled on cfg_load
- cfg_load  in  1  single-cycle pulse; latch cfg_len and restart the window
- in_data  in  WIDTH  new sample
- in_valid  in  1  in_data valid
- in_ready  out  1  controller accepts; transfer when in_valid && in_ready
- mem_rd_en  out  1  RAM read strobe
- mem_rd_addr  out  AW  RAM read address
- mem_rd_data  in  WIDTH  RAM read data, valid exactly 1 cycle after mem_rd_en
- mem_wr_en  out  1  RAM write strobe
- mem_wr_addr  out  AW  RAM write address
- mem_wr_data  out  WIDTH  RAM write data
- out_new  out  WIDTH  accepted sample
- out_old  out  WIDTH  evicted sample (0 while filling)
- out_valid  out  1  pair valid
- out_ready  in  1  downstream accepts pair
- primed  out  1  window holds len samples

## Operation
- Reset: state IDLE, len=MAX_DEPTH, ptr=0, fill=0; all outputs 0 (in_ready=0, strobes=0, out_valid=0, primed=0).
- States: IDLE -> (cfg_load) FILL -> (fill reaches len) RUN; cfg_load from any state -> FILL.
- cfg_load: len = cfg_len clamped (0 -> 1, >MAX_DEPTH -> MAX_DEPTH); ptr=0, fill=0, primed=0; in-flight pipeline contents discarded, out_valid=0 next cycle. in_ready is forced low in the cfg_load cycle; a sample presented then is not accepted.
- IDLE: in_ready=0.
- Accept at cycle T (FILL or RUN): mem_rd_en=1, mem_rd_addr=ptr in T. In T+1: mem_wr_en=1, mem_wr_addr=ptr_T, mem_wr_data=sample. ptr advances, wrapping len-1 -> 0.
- Old-sample selection: FILL -> 0; RUN -> mem_rd_data, except when T+1 write address equals the T read address of the following accept (len=1 back-to-back): forward the registered write data instead. No read-during-write behaviour is required of the RAM.
- fill increments per accept in FILL; when it reaches len, state=RUN and primed=1 from the cycle after that accept.
- Output pair registered; held stable while out_valid && !out_ready.
- Backpressure: two pipeline stages (read-issue, output). in_ready=0 only when both are occupied and out_ready=0. No sample is dropped or duplicated.

## Timing
- Latency: accept at T -> out_valid at T+2.
- Throughput: 1 pair/cycle with out_ready held high, any len including 1.
- RAM write trails read of the same address by 1 cycle.
- primed rises at T+1 of the len-th accept; state transition FILL -> RUN occurs in the same edge.
- reset mid-stream: immediate clear, no outputs until the next cfg_load.

## Configuration
- WINDOW_CTRL_FILL_OUT_EN defined: pairs are emitted during FILL with out_old=0, so accumulators build from zero.
- Undefined: FILL accepts are still written to RAM, but out_valid is suppressed until RUN. The first emitted pair is the (len+1)-th sample with the 1st sample as out_old.

## Test plan
- Reset asserted mid-stream -> all outputs 0 within the same cycle; in_ready stays 0 until cfg_load.
- cfg_len=4, samples 1..8 back-to-back with FILL_OUT_EN -> pairs (1,0)(2,0)(3,0)(4,0)(5,1)(6,2)(7,3)(8,4); primed after the 4th accept.
- cfg_len=1, samples 10,11,12 back-to-back -> (11,10)(12,11) via forwarding; cfg_len=0 behaves as 1.
- cfg_len=3, out_ready low for 5 cycles during a stream -> in_ready drops after 2 pending; sequence resumes intact with no loss or duplication.
- cfg_load during RUN with in_valid high -> that sample is rejected and out_valid drops; the next samples pair with 0 (refill).
- cfg_len=MAX_DEPTH+5 -> clamped; the pointer wraps MAX_DEPTH-1 -> 0; out_old matches the sample MAX_DEPTH accepts earlier.
